pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipe_ctrl_load_use_det.sv | 31 +++
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall vector
// encodings, controller state type and the default exception vector.
package pipe_ctrl_pkg;

    // Stall vectors: highest set bit k holds stages 0..k and bubbles stage k+1.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DIV_WAIT   = 2'd1,
        FLUSH_PEND = 2'd2
    } ctrl_state_t;

    // Exception beats ERET when both commit in the same cycle.
    function automatic logic [31:0] redirect_target(
        input logic        excp_valid,
        input logic [31:0] epc,
        input logic [31:0] exc_vector
    );
        return excp_valid ? exc_vector : epc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_load_use_det.sv
// Combinational load-use detector: the instruction in ID reads a register
// that the load currently in EX has not yet produced. r0 never hazards.
module load_use_det
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_is_load_i,
    input  logic [4:0] ex_waddr_i,
    input  logic       id_re1_i,
    input  logic       id_re2_i,
    input  logic [4:0] id_raddr1_i,
    input  logic [4:0] id_raddr2_i,
    output logic       hit_o
);

    logic [1:0]      src_re;
    logic [1:0][4:0] src_addr;
    logic [1:0]      src_match;

    assign src_re   = {id_re2_i, id_re1_i};
    assign src_addr = {id_raddr2_i, id_raddr1_i};

    // One comparator per ID source operand.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_re[gi] && (src_addr[gi] == ex_waddr_i);
        end
    endgenerate

    assign hit_o = ex_is_load_i && (ex_waddr_i != 5'd0) && (|src_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Resolves load-use,
// multi-cycle divide, outstanding SRAM transactions and exception/ERET
// redirects; also counts cycles in which the PC is held.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             id_re1_i,
    input  logic             id_re2_i,
    input  logic [4:0]       id_raddr1_i,
    input  logic [4:0]       id_raddr2_i,
    input  logic             ex_is_load_i,
    input  logic [4:0]       ex_waddr_i,
    input  logic             ex_is_div_i,
    input  logic             div_done_i,
    output logic             div_start_o,
    output logic             div_cancel_o,
    input  logic             if_wait_i,
    input  logic             mem_wait_i,
    input  logic             excp_valid_i,
    input  logic             eret_i,
    input  logic [31:0]      epc_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    ctrl_state_t      state_q, state_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic             div_start_q, div_start_d;
    logic             div_cancel_q, div_cancel_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic        load_use;
    logic        exc_req;
    logic [31:0] exc_target;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_stall;
    logic [5:0]  stall;

    load_use_det u_load_use_det (
        .ex_is_load_i (ex_is_load_i),
        .ex_waddr_i   (ex_waddr_i),
        .id_re1_i     (id_re1_i),
        .id_re2_i     (id_re2_i),
        .id_raddr1_i  (id_raddr1_i),
        .id_raddr2_i  (id_raddr2_i),
        .hit_o        (load_use)
    );

    assign exc_req    = excp_valid_i || eret_i;
    assign exc_target = redirect_target(excp_valid_i, epc_i, EXC_VECTOR);

    // Next-state, flush strobe and divider handshake requests.
    always_comb begin
        state_d      = state_q;
        pend_pc_d    = pend_pc_q;
        div_start_d  = 1'b0;
        div_cancel_d = 1'b0;
        flush        = 1'b0;
        new_pc       = 32'd0;
        case (state_q)
            IDLE: begin
                // A committing exception kills the divide sitting in EX,
                // so it takes precedence over starting the divider.
                if (exc_req) begin
                    if (!mem_wait_i) begin
                        flush  = 1'b1;
                        new_pc = exc_target;
                    end else begin
                        state_d   = FLUSH_PEND;
                        pend_pc_d = exc_target;
                    end
                end else if (ex_is_div_i) begin
                    div_start_d = 1'b1;
                    state_d     = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (exc_req) begin
                    div_cancel_d = 1'b1;
                    if (!mem_wait_i) begin
                        flush   = 1'b1;
                        new_pc  = exc_target;
                        state_d = IDLE;
                    end else begin
                        state_d   = FLUSH_PEND;
                        pend_pc_d = exc_target;
                    end
                end else if (div_done_i) begin
                    state_d = IDLE;
                end
            end
            FLUSH_PEND: begin
                // Later exception inputs are ignored: the first one wins.
                if (!mem_wait_i) begin
                    flush   = 1'b1;
                    new_pc  = pend_pc_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n_i) begin
            flush  = 1'b0;
            new_pc = 32'd0;
        end
    end

    assign div_stall = ((state_q == DIV_WAIT) && !div_done_i) ||
                       ((state_q == IDLE) && ex_is_div_i);

    // Stall vector, highest-priority hazard first.
    always_comb begin
        stall = STALL_NONE;
        if (!rst_n_i || flush) begin
            stall = STALL_NONE;
        end else if (mem_wait_i) begin
            stall = STALL_MEM;
        end else if (div_stall) begin
            stall = STALL_EX;
        end else if (load_use) begin
            stall = STALL_ID;
        end else if (if_wait_i) begin
            stall = STALL_IF;
        end
    end

    // State, latched redirect target, handshake pulses and stall counter.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            pend_pc_q    <= 32'd0;
            div_start_q  <= 1'b0;
            div_cancel_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_pc_q    <= pend_pc_d;
            div_start_q  <= div_start_d;
            div_cancel_q <= div_cancel_d;
            if (stall[0]) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall_o      = stall;
    assign flush_o      = flush;
    assign new_pc_o     = new_pc;
    assign div_start_o  = div_start_q;
    assign div_cancel_o = div_cancel_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// stimulus, all checked every cycle against a behavioural reference model.
module tb_pipe_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_re1, id_re2;
    logic [4:0]  id_raddr1, id_raddr2;
    logic        ex_is_load;
    logic [4:0]  ex_waddr;
    logic        ex_is_div, div_done;
    logic        div_start, div_cancel;
    logic        if_wait, mem_wait;
    logic        excp_valid, eret;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;

    pipe_ctrl #(.EXC_VECTOR(VEC), .CNT_W(32)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .id_re1_i     (id_re1),
        .id_re2_i     (id_re2),
        .id_raddr1_i  (id_raddr1),
        .id_raddr2_i  (id_raddr2),
        .ex_is_load_i (ex_is_load),
        .ex_waddr_i   (ex_waddr),
        .ex_is_div_i  (ex_is_div),
        .div_done_i   (div_done),
        .div_start_o  (div_start),
        .div_cancel_o (div_cancel),
        .if_wait_i    (if_wait),
        .mem_wait_i   (mem_wait),
        .excp_valid_i (excp_valid),
        .eret_i       (eret),
        .epc_i        (epc),
        .stall_o      (stall),
        .flush_o      (flush),
        .new_pc_o     (new_pc),
        .stall_cnt_o  (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a divide in flight, a pending redirect, and the
    // registered outputs expected after the next edge.
    bit          m_busy, m_pend, m_start, m_cancel;
    logic [31:0] m_pend_pc, m_cnt;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; id_re1 = 0; id_re2 = 0; id_raddr1 = 0; id_raddr2 = 0;
        ex_is_load = 0; ex_waddr = 0; ex_is_div = 0; div_done = 0;
        if_wait = 0; mem_wait = 0; excp_valid = 0; eret = 0; epc = 0;
    endtask

    // Let inputs settle, derive expected outputs from the hazard rules, compare.
    task automatic settle();
        logic        exc, lu;
        logic [31:0] tgt;
        #1;
        exc = excp_valid || eret;
        tgt = excp_valid ? VEC : epc;
        lu  = ex_is_load && (ex_waddr != 0) &&
              ((id_re1 && id_raddr1 == ex_waddr) || (id_re2 && id_raddr2 == ex_waddr));
        if (!rst_n)      begin e_flush = 0; e_pc = 0; end
        else if (m_pend) begin e_flush = !mem_wait; e_pc = m_pend_pc; end
        else             begin e_flush = exc && !mem_wait; e_pc = tgt; end
        if (!rst_n || e_flush)                            e_stall = 6'b000000;
        else if (mem_wait)                                e_stall = 6'b011111;
        else if (m_busy ? !div_done : ex_is_div)          e_stall = 6'b001111;
        else if (lu)                                      e_stall = 6'b000111;
        else if (if_wait)                                 e_stall = 6'b000011;
        else                                              e_stall = 6'b000000;
        check("stall_o", 64'(stall), 64'(e_stall));
        check("flush_o", 64'(flush), 64'(e_flush));
        if (e_flush || !rst_n) check("new_pc_o", 64'(new_pc), 64'(e_pc));
        check("div_start_o", 64'(div_start), 64'(m_start));
        check("div_cancel_o", 64'(div_cancel), 64'(m_cancel));
        check("stall_cnt_o", 64'(stall_cnt), 64'(m_cnt));
    endtask

    // Apply the clock edge to the model, then move to the next drive point.
    task automatic advance();
        logic exc;
        logic [31:0] tgt;
        exc = excp_valid || eret;
        tgt = excp_valid ? VEC : epc;
        if (!rst_n) begin
            m_busy = 0; m_pend = 0; m_start = 0; m_cancel = 0; m_cnt = 0; m_pend_pc = 0;
        end else begin
            m_start = 0; m_cancel = 0;
            m_cnt = m_cnt + 32'(e_stall[0]);
            if (m_pend) begin
                if (!mem_wait) m_pend = 0;
            end else if (exc) begin
                if (m_busy) m_cancel = 1;
                m_busy = 0;
                if (mem_wait) begin m_pend = 1; m_pend_pc = tgt; end
            end else if (m_busy) begin
                if (div_done) m_busy = 0;
            end else if (ex_is_div) begin
                m_start = 1; m_busy = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    initial begin
        logic [31:0] c0;
        idle_inputs();
        rst_n = 1'b0;
        m_busy = 0; m_pend = 0; m_start = 0; m_cancel = 0; m_cnt = 0; m_pend_pc = 0;
        @(negedge clk);
        // Reset state
        tick();
        rst_n = 1'b1;
        tick();

        // Load-use hit: one stall cycle, then the load moves on
        ex_is_load = 1; ex_waddr = 5; id_re1 = 1; id_raddr1 = 5;
        settle(); check("load_use_hit", 64'(stall), 64'(6'b000111)); advance();
        ex_is_load = 0;
        settle(); check("load_use_after", 64'(stall), 64'(6'b000000)); advance();
        // Load to r0 never hazards
        ex_is_load = 1; ex_waddr = 0; id_raddr1 = 0;
        settle(); check("load_use_r0", 64'(stall), 64'(6'b000000)); advance();
        idle_inputs();

        // Divide: done 8 cycles after the start pulse
        c0 = stall_cnt;
        ex_is_div = 1;
        for (int i = 0; i < 9; i++) begin
            settle();
            check("div_stall", 64'(stall), 64'(6'b001111));
            check("div_start_pulse", 64'(div_start), 64'(i == 1));
            advance();
        end
        div_done = 1;
        settle(); check("div_done_release", 64'(stall), 64'(6'b000000)); advance();
        idle_inputs();
        settle();
        check("div_cnt_delta", 64'(stall_cnt - c0), 64'd9);
        check("div_no_restart", 64'(div_start), 64'd0);
        advance();

        // Exception during DIV_WAIT, memory idle
        ex_is_div = 1;
        tick(); tick(); tick();
        excp_valid = 1;
        settle();
        check("exc_div_flush", 64'(flush), 64'd1);
        check("exc_div_pc", 64'(new_pc), 64'(VEC));
        advance();
        idle_inputs();
        settle();
        check("exc_div_cancel", 64'(div_cancel), 64'd1);
        check("exc_div_nostall", 64'(stall), 64'd0);
        advance();
        tick();

        // Exception while the data SRAM is busy for 3 cycles; a later ERET is ignored
        excp_valid = 1; mem_wait = 1;
        settle(); check("pend_stall0", 64'(stall), 64'(6'b011111)); advance();
        excp_valid = 0; eret = 1; epc = 32'h1234_5678;
        settle(); check("pend_stall1", 64'(stall), 64'(6'b011111)); advance();
        eret = 0;
        settle(); check("pend_stall2", 64'(stall), 64'(6'b011111)); advance();
        mem_wait = 0;
        settle();
        check("pend_flush", 64'(flush), 64'd1);
        check("pend_pc", 64'(new_pc), 64'(VEC));
        advance();
        settle(); check("pend_one_strobe", 64'(flush), 64'd0); advance();

        // ERET redirect, and exception winning over ERET
        eret = 1; epc = 32'h8000_1234;
        settle(); check("eret_pc", 64'(new_pc), 64'h8000_1234); advance();
        excp_valid = 1;
        settle(); check("eret_excp_pc", 64'(new_pc), 64'(VEC)); advance();
        idle_inputs();

        // Memory wait beats load-use and fetch wait
        mem_wait = 1; if_wait = 1; ex_is_load = 1; ex_waddr = 7; id_re2 = 1; id_raddr2 = 7;
        settle(); check("prio_mem", 64'(stall), 64'(6'b011111)); advance();
        idle_inputs();

        // Reset in the middle of a divide
        ex_is_div = 1;
        tick(); tick();
        rst_n = 0;
        settle(); check("rst_comb_stall", 64'(stall), 64'd0); advance();
        settle();
        check("rst_cnt", 64'(stall_cnt), 64'd0);
        check("rst_cancel", 64'(div_cancel), 64'd0);
        check("rst_start", 64'(div_start), 64'd0);
        advance();
        idle_inputs();
        tick(); tick();

        // Random phase
        for (int i = 0; i < 600; i++) begin
            rst_n      = ($urandom_range(0, 63) != 0);
            id_re1     = 1'($urandom_range(0, 1));
            id_re2     = 1'($urandom_range(0, 1));
            id_raddr1  = 5'($urandom_range(0, 3));
            id_raddr2  = 5'($urandom_range(0, 3));
            ex_is_load = 1'($urandom_range(0, 1));
            ex_waddr   = 5'($urandom_range(0, 3));
            ex_is_div  = ($urandom_range(0, 5) == 0);
            div_done   = ($urandom_range(0, 5) == 0);
            if_wait    = ($urandom_range(0, 3) == 0);
            mem_wait   = ($urandom_range(0, 3) == 0);
            excp_valid = ($urandom_range(0, 15) == 0);
            eret       = ($urandom_range(0, 15) == 0);
            epc        = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
